// File: rtl/sp_sram_dma_arbiter.sv
// sp_sram_dma_arbiter: single-port SRAM arbiter with a block-copy DMA.
// CTL always owns the port when it asks; DMA fills the idle cycles.
module sp_sram_dma_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ctl_sram_EN,
  input  logic              ctl_sram_WE,
  input  logic [ADDR_W-1:0] ctl_sram_ADDR,
  input  logic [DATA_W-1:0] ctl_sram_DI,
  output logic [DATA_W-1:0] ctl_sram_DO,
  input  logic              dma_start,
  input  logic [ADDR_W-1:0] dma_src,
  input  logic [ADDR_W-1:0] dma_dst,
  input  logic [ADDR_W-1:0] dma_len,
  output logic              dma_busy,
  output logic              dma_done,
  output logic              sram_EN,
  output logic              sram_WE,
  output logic [ADDR_W-1:0] sram_ADDR,
  output logic [DATA_W-1:0] sram_DI,
  input  logic [DATA_W-1:0] sram_DO
);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    CAP,
    WR
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   src;
  logic [ADDR_W-1:0]   dst;
  logic [ADDR_W-1:0]   len;
  logic [ADDR_W-1:0]   idx;
  logic [DATA_W-1:0]   data_buf;
  logic                grant;
  logic                last;

  assign ctl_sram_DO = sram_DO;
  assign grant       = ~ctl_sram_EN;
  assign last        = (idx == len - ADDR_W'(1));

  // Port mux: CTL first, then a pending DMA read/write, else all zero.
  always_comb begin
    sram_EN   = 1'b0;
    sram_WE   = 1'b0;
    sram_ADDR = '0;
    sram_DI   = '0;
    if (ctl_sram_EN) begin
      sram_EN   = 1'b1;
      sram_WE   = ctl_sram_WE;
      sram_ADDR = ctl_sram_ADDR;
      sram_DI   = ctl_sram_DI;
    end else if (state == RD) begin
      sram_EN   = 1'b1;
      sram_ADDR = src + idx;
    end else if (state == WR) begin
      sram_EN   = 1'b1;
      sram_WE   = 1'b1;
      sram_ADDR = dst + idx;
      sram_DI   = data_buf;
    end
  end

  // Copy engine: read word, capture it, write it, repeat until len words.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      src      <= '0;
      dst      <= '0;
      len      <= '0;
      idx      <= '0;
      data_buf <= '0;
      dma_busy <= 1'b0;
      dma_done <= 1'b0;
    end else begin
      dma_done <= 1'b0;
      case (state)
        IDLE: begin
          if (dma_start) begin
            src <= dma_src;
            dst <= dma_dst;
            len <= dma_len;
            idx <= '0;
            if (dma_len == '0) begin
              dma_done <= 1'b1;
            end else begin
              state    <= RD;
              dma_busy <= 1'b1;
            end
          end
        end
        RD: begin
          if (grant) begin
            state <= CAP;
          end
        end
        CAP: begin
          // Read data shows up one cycle after the granted read.
          data_buf <= sram_DO;
          state    <= WR;
        end
        WR: begin
          if (grant) begin
            if (last) begin
              state    <= IDLE;
              dma_busy <= 1'b0;
              dma_done <= 1'b1;
            end else begin
              idx   <= idx + ADDR_W'(1);
              state <= RD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sp_sram_dma_arbiter.sv
// tb_sp_sram_dma_arbiter: directed bench for the SRAM arbiter + DMA.
// Owns a behavioural single-port SRAM behind the DUT.
module tb_sp_sram_dma_arbiter;

  logic        clk;
  logic        reset;
  logic        ctl_sram_EN;
  logic        ctl_sram_WE;
  logic [15:0] ctl_sram_ADDR;
  logic [31:0] ctl_sram_DI;
  logic [31:0] ctl_sram_DO;
  logic        dma_start;
  logic [15:0] dma_src;
  logic [15:0] dma_dst;
  logic [15:0] dma_len;
  logic        dma_busy;
  logic        dma_done;
  logic        sram_EN;
  logic        sram_WE;
  logic [15:0] sram_ADDR;
  logic [31:0] sram_DI;
  logic [31:0] sram_DO;

  logic [31:0] mem [0:65535];

  int n_cmp;
  int n_bad;

  int done_cyc;
  int done_count;
  int busy_at_done;
  int busy_before;
  int acc_count;
  int busy_seen;
  logic [15:0] rd_q[$];
  logic [48:0] exp_q[$];
  logic [48:0] obs_q[$];
  logic [31:0] rdat_q[$];

  sp_sram_dma_arbiter #(.ADDR_W(16), .DATA_W(32)) dut (
    .clk(clk),
    .reset(reset),
    .ctl_sram_EN(ctl_sram_EN),
    .ctl_sram_WE(ctl_sram_WE),
    .ctl_sram_ADDR(ctl_sram_ADDR),
    .ctl_sram_DI(ctl_sram_DI),
    .ctl_sram_DO(ctl_sram_DO),
    .dma_start(dma_start),
    .dma_src(dma_src),
    .dma_dst(dma_dst),
    .dma_len(dma_len),
    .dma_busy(dma_busy),
    .dma_done(dma_done),
    .sram_EN(sram_EN),
    .sram_WE(sram_WE),
    .sram_ADDR(sram_ADDR),
    .sram_DI(sram_DI),
    .sram_DO(sram_DO)
  );

  always #5 clk = ~clk;

  // Single-port SRAM, read data registered.
  always @(posedge clk) begin
    if (sram_EN) begin
      if (sram_WE) mem[sram_ADDR] <= sram_DI;
      else sram_DO <= mem[sram_ADDR];
    end
  end

  task automatic ctl_idle();
    ctl_sram_EN   = 1'b0;
    ctl_sram_WE   = 1'b0;
    ctl_sram_ADDR = '0;
    ctl_sram_DI   = '0;
  endtask

  task automatic ctl_write(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    ctl_sram_EN   = 1'b1;
    ctl_sram_WE   = 1'b1;
    ctl_sram_ADDR = a;
    ctl_sram_DI   = d;
    @(negedge clk);
    ctl_idle();
  endtask

  // Launches a copy and records what the port and status lines did.
  // Cycle 0 is the first cycle after the accepted start edge.
  task automatic run_copy(
    input logic [15:0] s, input logic [15:0] d, input logic [15:0] n,
    input bit contend, input int restart_at
  );
    bit prev_rd;
    int k;
    done_cyc     = -1;
    done_count   = 0;
    busy_at_done = -1;
    busy_before  = -1;
    acc_count    = 0;
    busy_seen    = 0;
    prev_rd      = 0;
    rd_q.delete();
    exp_q.delete();
    obs_q.delete();
    rdat_q.delete();
    @(negedge clk);
    dma_start = 1'b1;
    dma_src   = s;
    dma_dst   = d;
    dma_len   = n;
    for (int c = 0; c <= 80; c++) begin
      @(negedge clk);
      dma_start = 1'b0;
      ctl_idle();
      if (c == restart_at) begin
        dma_start = 1'b1;
        dma_src   = 16'h0300;
        dma_dst   = 16'h0400;
        dma_len   = 16'd2;
      end
      if (contend && (c % 2 == 1)) begin
        k = c / 2;
        ctl_sram_EN = 1'b1;
        if (k % 2 == 0) begin
          ctl_sram_WE   = 1'b1;
          ctl_sram_ADDR = 16'h0050 + 16'(k);
          ctl_sram_DI   = 32'h000000A0 + 32'(k);
        end else begin
          ctl_sram_ADDR = 16'h0060;
          ctl_sram_DI   = 32'h0;
        end
      end
      #1;
      if (prev_rd) rdat_q.push_back(ctl_sram_DO);
      prev_rd = ctl_sram_EN && !ctl_sram_WE;
      if (ctl_sram_EN) begin
        exp_q.push_back({1'b1, ctl_sram_ADDR, ctl_sram_WE, ctl_sram_DI});
        obs_q.push_back({sram_EN, sram_ADDR, sram_WE, sram_DI});
      end else if (sram_EN) begin
        acc_count++;
        if (!sram_WE) rd_q.push_back(sram_ADDR);
      end
      if (dma_busy) busy_seen = 1;
      if (dma_done) begin
        done_count++;
        if (done_cyc < 0) begin
          done_cyc     = c;
          busy_at_done = int'(dma_busy);
        end
      end
      if (done_cyc < 0) busy_before = int'(dma_busy);
      if (done_cyc >= 0 && c >= done_cyc + 2) break;
    end
    @(negedge clk);
    ctl_idle();
    dma_start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (dma_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_busy got=%b want=0", dma_busy);
    end
    n_cmp++;
    if (dma_done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_done got=%b want=0", dma_done);
    end
    n_cmp++;
    if ({sram_EN, sram_WE, sram_ADDR, sram_DI} !== 50'h0) begin
      n_bad++;
      $display("FAIL reset_port got=%b/%b/%h/%h want=0/0/0000/00000000",
               sram_EN, sram_WE, sram_ADDR, sram_DI);
    end
  endtask

  task automatic test_passthrough();
    ctl_write(16'h0010, 32'hDEADBEEF);
    @(negedge clk);
    ctl_sram_EN   = 1'b1;
    ctl_sram_WE   = 1'b0;
    ctl_sram_ADDR = 16'h0010;
    ctl_sram_DI   = 32'h12345678;
    #1;
    n_cmp++;
    if ({sram_EN, sram_WE, sram_ADDR, sram_DI} !==
        {1'b1, 1'b0, 16'h0010, 32'h12345678}) begin
      n_bad++;
      $display("FAIL pass_mirror got=%b/%b/%h/%h want=1/0/0010/12345678",
               sram_EN, sram_WE, sram_ADDR, sram_DI);
    end
    @(negedge clk);
    ctl_idle();
    n_cmp++;
    if (ctl_sram_DO !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL pass_rdata got=%h want=deadbeef", ctl_sram_DO);
    end
    n_cmp++;
    if (dma_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL pass_busy got=%b want=0", dma_busy);
    end
  endtask

  task automatic load_src_and_sentinel();
    for (int i = 0; i < 4; i++) ctl_write(16'h0100 + 16'(i), 32'(i + 1));
    for (int i = 0; i < 4; i++) ctl_write(16'h0200 + 16'(i), 32'hFFFFFFFF);
  endtask

  task automatic test_basic_copy();
    load_src_and_sentinel();
    run_copy(16'h0100, 16'h0200, 16'd4, 1'b0, -1);
    n_cmp++;
    if (done_cyc !== 12) begin
      n_bad++;
      $display("FAIL basic_done_cycle got=%0d want=12", done_cyc);
    end
    n_cmp++;
    if (busy_at_done !== 0 || busy_before !== 1) begin
      n_bad++;
      $display("FAIL basic_busy got=%0d->%0d want=1->0",
               busy_before, busy_at_done);
    end
    n_cmp++;
    if (done_count !== 1) begin
      n_bad++;
      $display("FAIL basic_done_count got=%0d want=1", done_count);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (mem[16'h0200 + 16'(i)] !== 32'(i + 1)) begin
        n_bad++;
        $display("FAIL basic_mem[%0d] got=%h want=%h",
                 i, mem[16'h0200 + 16'(i)], 32'(i + 1));
      end
    end
    n_cmp++;
    if (acc_count !== 8) begin
      n_bad++;
      $display("FAIL basic_accesses got=%0d want=8", acc_count);
    end
  endtask

  task automatic test_contention();
    load_src_and_sentinel();
    ctl_write(16'h0060, 32'hCAFEF00D);
    run_copy(16'h0100, 16'h0200, 16'd4, 1'b1, -1);
    n_cmp++;
    if (done_cyc !== 15) begin
      n_bad++;
      $display("FAIL cont_done_cycle got=%0d want=15", done_cyc);
    end
    n_cmp++;
    if (obs_q.size() !== 9 || exp_q.size() !== 9) begin
      n_bad++;
      $display("FAIL cont_ctl_cycles got=%0d want=9", obs_q.size());
    end
    for (int i = 0; i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL cont_mirror[%0d] got=%h want=%h",
                 i, obs_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (rdat_q.size() !== 4) begin
      n_bad++;
      $display("FAIL cont_reads got=%0d want=4", rdat_q.size());
    end
    for (int i = 0; i < rdat_q.size(); i++) begin
      n_cmp++;
      if (rdat_q[i] !== 32'hCAFEF00D) begin
        n_bad++;
        $display("FAIL cont_rdata[%0d] got=%h want=cafef00d", i, rdat_q[i]);
      end
    end
    for (int k = 0; k <= 8; k += 2) begin
      n_cmp++;
      if (mem[16'h0050 + 16'(k)] !== 32'h000000A0 + 32'(k)) begin
        n_bad++;
        $display("FAIL cont_ctl_mem[%0d] got=%h want=%h",
                 k, mem[16'h0050 + 16'(k)], 32'h000000A0 + 32'(k));
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (mem[16'h0200 + 16'(i)] !== 32'(i + 1)) begin
        n_bad++;
        $display("FAIL cont_mem[%0d] got=%h want=%h",
                 i, mem[16'h0200 + 16'(i)], 32'(i + 1));
      end
    end
  endtask

  task automatic test_wrap();
    logic [15:0] ea [4];
    logic [31:0] ed [4];
    ea = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    ed = '{32'h11, 32'h22, 32'h33, 32'h44};
    for (int i = 0; i < 4; i++) ctl_write(ea[i], ed[i]);
    for (int i = 0; i < 4; i++) ctl_write(16'h0010 + 16'(i), 32'hFFFFFFFF);
    run_copy(16'hFFFE, 16'h0010, 16'd4, 1'b0, -1);
    n_cmp++;
    if (rd_q.size() !== 4) begin
      n_bad++;
      $display("FAIL wrap_nreads got=%0d want=4", rd_q.size());
    end
    for (int i = 0; i < rd_q.size(); i++) begin
      n_cmp++;
      if (rd_q[i] !== ea[i]) begin
        n_bad++;
        $display("FAIL wrap_raddr[%0d] got=%h want=%h", i, rd_q[i], ea[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (mem[16'h0010 + 16'(i)] !== ed[i]) begin
        n_bad++;
        $display("FAIL wrap_mem[%0d] got=%h want=%h",
                 i, mem[16'h0010 + 16'(i)], ed[i]);
      end
    end
  endtask

  task automatic test_len0();
    run_copy(16'h0500, 16'h0600, 16'd0, 1'b0, -1);
    n_cmp++;
    if (done_cyc !== 0) begin
      n_bad++;
      $display("FAIL len0_done_cycle got=%0d want=0", done_cyc);
    end
    n_cmp++;
    if (done_count !== 1) begin
      n_bad++;
      $display("FAIL len0_done_count got=%0d want=1", done_count);
    end
    n_cmp++;
    if (acc_count !== 0) begin
      n_bad++;
      $display("FAIL len0_accesses got=%0d want=0", acc_count);
    end
    n_cmp++;
    if (busy_seen !== 0) begin
      n_bad++;
      $display("FAIL len0_busy got=%0d want=0", busy_seen);
    end
  endtask

  task automatic test_start_while_busy();
    load_src_and_sentinel();
    ctl_write(16'h0300, 32'h00000099);
    ctl_write(16'h0400, 32'h00000BAD);
    run_copy(16'h0100, 16'h0200, 16'd4, 1'b0, 3);
    n_cmp++;
    if (done_cyc !== 12 || done_count !== 1) begin
      n_bad++;
      $display("FAIL swb_done got=%0d/%0d want=12/1", done_cyc, done_count);
    end
    n_cmp++;
    if (mem[16'h0400] !== 32'h00000BAD) begin
      n_bad++;
      $display("FAIL swb_dst2 got=%h want=00000bad", mem[16'h0400]);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (rd_q[i] !== 16'h0100 + 16'(i)) begin
        n_bad++;
        $display("FAIL swb_raddr[%0d] got=%h want=%h",
                 i, rd_q[i], 16'h0100 + 16'(i));
      end
      n_cmp++;
      if (mem[16'h0200 + 16'(i)] !== 32'(i + 1)) begin
        n_bad++;
        $display("FAIL swb_mem[%0d] got=%h want=%h",
                 i, mem[16'h0200 + 16'(i)], 32'(i + 1));
      end
    end
  endtask

  task automatic test_reset_mid_copy();
    int dones;
    int accs;
    load_src_and_sentinel();
    @(negedge clk);
    dma_start = 1'b1;
    dma_src   = 16'h0100;
    dma_dst   = 16'h0200;
    dma_len   = 16'd4;
    @(negedge clk);
    dma_start = 1'b0;
    repeat (6) @(negedge clk);
    n_cmp++;
    if (dma_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL rmid_busy_pre got=%b want=1", dma_busy);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if (dma_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rmid_busy_post got=%b want=0", dma_busy);
    end
    dones = 0;
    accs  = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      if (dma_done) dones++;
      if (sram_EN) accs++;
    end
    n_cmp++;
    if (dones !== 0 || accs !== 0) begin
      n_bad++;
      $display("FAIL rmid_quiet got=%0d/%0d want=0/0", dones, accs);
    end
    n_cmp++;
    if (mem[16'h0200] !== 32'd1 || mem[16'h0201] !== 32'd2) begin
      n_bad++;
      $display("FAIL rmid_done_words got=%h/%h want=1/2",
               mem[16'h0200], mem[16'h0201]);
    end
    n_cmp++;
    if (mem[16'h0202] !== 32'hFFFFFFFF || mem[16'h0203] !== 32'hFFFFFFFF) begin
      n_bad++;
      $display("FAIL rmid_untouched got=%h/%h want=ffffffff",
               mem[16'h0202], mem[16'h0203]);
    end
    run_copy(16'h0100, 16'h0200, 16'd4, 1'b0, -1);
    n_cmp++;
    if (done_cyc !== 12) begin
      n_bad++;
      $display("FAIL rmid_restart_done got=%0d want=12", done_cyc);
    end
    n_cmp++;
    if (mem[16'h0203] !== 32'd4) begin
      n_bad++;
      $display("FAIL rmid_restart_mem got=%h want=4", mem[16'h0203]);
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    clk       = 1'b0;
    reset     = 1'b1;
    dma_start = 1'b0;
    dma_src   = '0;
    dma_dst   = '0;
    dma_len   = '0;
    sram_DO   = '0;
    ctl_idle();
    test_reset();
    test_passthrough();
    test_basic_copy();
    test_contention();
    test_wrap();
    test_len0();
    test_start_while_busy();
    test_reset_mid_copy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
